// File: rtl/byte_striping_ctrl_if.sv
// Framer-side handshake and lane-write bus of the byte-striping controller.
// The master is the framer/lane-register side and the slave is the controller.
interface byte_striping_ctrl_if #(
    parameter int DATA_W    = 8,
    parameter int NUM_LANES = 4
);
    localparam int LANE_W = $clog2(NUM_LANES);

    logic [NUM_LANES-1:0] lane_en;
    logic [DATA_W-1:0]    in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic [DATA_W-1:0]    stripe_data;
    logic [NUM_LANES-1:0] stripe_wr;
    logic [LANE_W-1:0]    stripe_lane;
    logic                 group_vld;
    logic                 busy;
    logic                 cfg_err;

    modport master (
        output lane_en, in_data, in_valid, in_last,
        input  in_ready, stripe_data, stripe_wr, stripe_lane, group_vld, busy, cfg_err
    );

    modport slave (
        input  lane_en, in_data, in_valid, in_last,
        output in_ready, stripe_data, stripe_wr, stripe_lane, group_vld, busy, cfg_err
    );
endinterface

// File: rtl/byte_striping_ctrl.sv
// Stripes a framed byte stream over the enabled subset of lanes and pads a
// partial final group so that every frame ends on a complete group.
//
// state  | meaning
// IDLE   | between frames; first byte latches the lane mask
// STRIPE | mid-frame, writing accepted bytes round-robin over the mask
// PAD    | frame ended early; filling the remaining enabled lanes with PAD_BYTE
module byte_striping_ctrl #(
    parameter int                DATA_W    = 8,
    parameter int                NUM_LANES = 4,
    parameter logic [DATA_W-1:0] PAD_BYTE  = DATA_W'(8'hF7)
) (
    input logic                 clk1Mhz,
    input logic                 reset,
    byte_striping_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_LANES);

    typedef enum logic [1:0] {IDLE, STRIPE, PAD} state_t;

    state_t               state_q, state_d;
    logic [NUM_LANES-1:0] mask_q, mask_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [DATA_W-1:0]    stripe_data_q;
    logic [NUM_LANES-1:0] stripe_wr_q;
    logic [PTR_W-1:0]     stripe_lane_q;
    logic                 group_vld_q;

    logic                 accept;
    logic                 wr_en;
    logic [PTR_W-1:0]     wr_lane;
    logic [DATA_W-1:0]    wr_data;
    logic [NUM_LANES-1:0] wr_mask;

    function automatic logic [PTR_W-1:0] lowest_lane(input logic [NUM_LANES-1:0] m);
        lowest_lane = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--)
            if (m[i]) lowest_lane = PTR_W'(i);
    endfunction

    function automatic logic [PTR_W-1:0] highest_lane(input logic [NUM_LANES-1:0] m);
        highest_lane = '0;
        for (int i = 0; i < NUM_LANES; i++)
            if (m[i]) highest_lane = PTR_W'(i);
    endfunction

    // Smallest enabled lane above p, wrapping to the lowest enabled lane.
    function automatic logic [PTR_W-1:0] next_lane(input logic [NUM_LANES-1:0] m,
                                                   input logic [PTR_W-1:0]     p);
        next_lane = lowest_lane(m);
        for (int i = NUM_LANES - 1; i >= 0; i--)
            if (m[i] && (i > int'(p))) next_lane = PTR_W'(i);
    endfunction

    always_comb begin
        bus.in_ready = 1'b0;
        unique case (state_q)
            IDLE:    bus.in_ready = (bus.lane_en != '0);
            STRIPE:  bus.in_ready = 1'b1;
            default: bus.in_ready = 1'b0;
        endcase
    end

    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        wr_lane = ptr_q;
        wr_data = bus.in_data;
        wr_mask = mask_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    wr_en   = 1'b1;
                    wr_lane = lowest_lane(bus.lane_en);
                    wr_mask = bus.lane_en;
                    mask_d  = bus.lane_en;
                    ptr_d   = next_lane(bus.lane_en, lowest_lane(bus.lane_en));
                    if (!bus.in_last)
                        state_d = STRIPE;
                    else if (lowest_lane(bus.lane_en) != highest_lane(bus.lane_en))
                        state_d = PAD;
                end
            end
            STRIPE: begin
                if (accept) begin
                    wr_en = 1'b1;
                    ptr_d = next_lane(mask_q, ptr_q);
                    if (bus.in_last)
                        state_d = (ptr_q == highest_lane(mask_q)) ? IDLE : PAD;
                end
            end
            PAD: begin
                wr_en   = 1'b1;
                wr_data = PAD_BYTE;
                ptr_d   = next_lane(mask_q, ptr_q);
                if (ptr_q == highest_lane(mask_q)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk1Mhz) begin
        if (reset) begin
            state_q       <= IDLE;
            mask_q        <= '0;
            ptr_q         <= '0;
            stripe_data_q <= '0;
            stripe_wr_q   <= '0;
            stripe_lane_q <= '0;
            group_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            ptr_q       <= ptr_d;
            stripe_wr_q <= wr_en ? ({{(NUM_LANES-1){1'b0}}, 1'b1} << wr_lane) : '0;
            group_vld_q <= wr_en && (wr_lane == highest_lane(wr_mask));
            if (wr_en) begin
                stripe_data_q <= wr_data;
                stripe_lane_q <= wr_lane;
            end
        end
    end

    assign bus.stripe_data = stripe_data_q;
    assign bus.stripe_wr   = stripe_wr_q;
    assign bus.stripe_lane = stripe_lane_q;
    assign bus.group_vld   = group_vld_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.cfg_err     = (state_q == IDLE) && (bus.lane_en == '0);
endmodule

// File: tb/tb_byte_striping_ctrl.sv
// Bench for byte_striping_ctrl: a frame-level lane-list model checked against
// the DUT every cycle, plus literal write logs per directed scenario.
module tb_byte_striping_ctrl;
    logic clk1Mhz;
    logic reset;

    byte_striping_ctrl_if bus ();

    byte_striping_ctrl dut (
        .clk1Mhz (clk1Mhz),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk1Mhz = 1'b0;
    always #5 clk1Mhz = ~clk1Mhz;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: list of enabled lanes for the current frame, position in it, pads owed.
    int           m_lanes[$];
    int           m_pos      = 0;
    int           m_pad_left = 0;
    bit           m_active   = 0;
    bit           chk_en     = 0;
    logic [3:0]   e_wr       = '0;
    logic         e_gv       = 1'b0;
    logic [7:0]   e_data     = '0;
    logic [1:0]   e_lane     = '0;
    bit           e_rst      = 0;
    logic [10:0]  log_q[$];

    function automatic bit model_ready();
        if (m_pad_left > 0) return 1'b0;
        if (m_active)       return 1'b1;
        return (bus.lane_en != 4'h0);
    endfunction

    task automatic emit(input int lane, input logic [7:0] data, input bit gv);
        e_wr   = 4'b0001 << lane;
        e_lane = 2'(lane);
        e_data = data;
        e_gv   = gv;
        log_q.push_back({gv, 2'(lane), data});
    endtask

    always @(posedge clk1Mhz) begin
        bit rdy;
        rdy   = model_ready();
        e_rst = 0;
        e_wr  = '0;
        e_gv  = 1'b0;
        if (reset) begin
            m_active   = 0;
            m_pad_left = 0;
            m_pos      = 0;
            e_rst      = 1;
            e_data     = '0;
            e_lane     = '0;
            chk_en     = 1;
        end else if (m_pad_left > 0) begin
            emit(m_lanes[m_pos], 8'hF7, m_pos == m_lanes.size() - 1);
            m_pos++;
            m_pad_left--;
            if (m_pad_left == 0) m_active = 0;
        end else if (bus.in_valid && rdy) begin
            if (!m_active) begin
                m_lanes.delete();
                for (int i = 0; i < 4; i++) if (bus.lane_en[i]) m_lanes.push_back(i);
                m_pos    = 0;
                m_active = 1;
            end
            emit(m_lanes[m_pos], bus.in_data, m_pos == m_lanes.size() - 1);
            if (bus.in_last) begin
                m_pad_left = m_lanes.size() - 1 - m_pos;
                m_pos++;
                if (m_pad_left == 0) m_active = 0;
            end else begin
                m_pos = (m_pos + 1) % m_lanes.size();
            end
        end
    end

    always @(negedge clk1Mhz) begin
        if (chk_en) begin
            chk("in_ready", 32'(bus.in_ready), 32'(model_ready()));
            chk("busy", 32'(bus.busy), 32'(m_active));
            chk("cfg_err", 32'(bus.cfg_err), 32'(!m_active && bus.lane_en == 4'h0));
            chk("stripe_wr", 32'(bus.stripe_wr), 32'(e_wr));
            chk("group_vld", 32'(bus.group_vld), 32'(e_gv));
            if (e_wr != 4'h0 || e_rst) begin
                chk("stripe_data", 32'(bus.stripe_data), 32'(e_data));
                chk("stripe_lane", 32'(bus.stripe_lane), 32'(e_lane));
            end
        end
    end

    task automatic step();
        @(posedge clk1Mhz);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        bit done;
        done         = 0;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk1Mhz);
            done = bus.in_ready;
            step();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!done) chk("send_timeout", 32'(done), 32'd1);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (n) step();
    endtask

    // Entry = {group_vld, lane, data}; pins the model against hand-worked results.
    task automatic check_log(input string name, input logic [10:0] exp[$]);
        chk({name, "_len"}, 32'(log_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < log_q.size(); i++)
            chk($sformatf("%s_%0d", name, i), 32'(log_q[i]), 32'(exp[i]));
        log_q.delete();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        bus.lane_en  = 4'hF;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk1Mhz);
        chk("rst_wr", 32'(bus.stripe_wr), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        step();
        log_q.delete();

        // 1: four lanes, eight bytes
        for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
        idle(3);
        check_log("t1", '{{1'b0, 2'd0, 8'h01}, {1'b0, 2'd1, 8'h02}, {1'b0, 2'd2, 8'h03},
                         {1'b1, 2'd3, 8'h04}, {1'b0, 2'd0, 8'h05}, {1'b0, 2'd1, 8'h06},
                         {1'b0, 2'd2, 8'h07}, {1'b1, 2'd3, 8'h08}});

        // 2: sparse mask with pad
        bus.lane_en = 4'b0101;
        send(8'hA0, 1'b0);
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b1);
        @(negedge clk1Mhz);
        chk("t2_pad_ready", 32'(bus.in_ready), 32'd0);
        chk("t2_pad_busy", 32'(bus.busy), 32'd1);
        idle(3);
        check_log("t2", '{{1'b0, 2'd0, 8'hA0}, {1'b1, 2'd2, 8'hA1}, {1'b0, 2'd0, 8'hA2},
                         {1'b1, 2'd2, 8'hF7}});

        // 3: bubbles mid-frame
        bus.lane_en = 4'hF;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        idle(2);
        @(negedge clk1Mhz);
        chk("t3_gap_wr", 32'(bus.stripe_wr), 32'd0);
        idle(1);
        send(8'h33, 1'b1);
        idle(3);
        check_log("t3", '{{1'b0, 2'd0, 8'h11}, {1'b0, 2'd1, 8'h22}, {1'b0, 2'd2, 8'h33},
                         {1'b1, 2'd3, 8'hF7}});

        // 4: lane_en change mid-frame, then back-to-back frame with new mask
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        bus.lane_en = 4'b0011;
        send(8'hC3, 1'b0);
        send(8'hC4, 1'b0);
        send(8'hC5, 1'b1);
        send(8'hD1, 1'b0);
        send(8'hD2, 1'b1);
        idle(3);
        check_log("t4", '{{1'b0, 2'd0, 8'hC1}, {1'b0, 2'd1, 8'hC2}, {1'b0, 2'd2, 8'hC3},
                         {1'b1, 2'd3, 8'hC4}, {1'b0, 2'd0, 8'hC5}, {1'b0, 2'd1, 8'hF7},
                         {1'b0, 2'd2, 8'hF7}, {1'b1, 2'd3, 8'hF7}, {1'b0, 2'd0, 8'hD1},
                         {1'b1, 2'd1, 8'hD2}});

        // 5: reset mid-frame
        bus.lane_en = 4'hF;
        send(8'hE1, 1'b0);
        send(8'hE2, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk1Mhz);
        chk("t5_wr", 32'(bus.stripe_wr), 32'd0);
        chk("t5_gv", 32'(bus.group_vld), 32'd0);
        chk("t5_data", 32'(bus.stripe_data), 32'd0);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        step();
        send(8'hE3, 1'b0);
        send(8'hE4, 1'b0);
        send(8'hE5, 1'b0);
        send(8'hE6, 1'b1);
        idle(3);
        check_log("t5", '{{1'b0, 2'd0, 8'hE1}, {1'b0, 2'd1, 8'hE2}, {1'b0, 2'd0, 8'hE3},
                         {1'b0, 2'd1, 8'hE4}, {1'b0, 2'd2, 8'hE5}, {1'b1, 2'd3, 8'hE6}});

        // 6: empty mask, then single-lane mask
        bus.lane_en  = 4'h0;
        bus.in_data  = 8'h55;
        bus.in_last  = 1'b1;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk1Mhz);
            chk("t6_cfg_err", 32'(bus.cfg_err), 32'd1);
            chk("t6_ready", 32'(bus.in_ready), 32'd0);
            chk("t6_wr", 32'(bus.stripe_wr), 32'd0);
            step();
        end
        idle(1);
        bus.lane_en = 4'b1000;
        send(8'h66, 1'b1);
        @(negedge clk1Mhz);
        chk("t6_lane3_wr", 32'(bus.stripe_wr), 32'h8);
        chk("t6_lane3_gv", 32'(bus.group_vld), 32'd1);
        chk("t6_busy", 32'(bus.busy), 32'd0);
        idle(2);
        check_log("t6", '{{1'b1, 2'd3, 8'h66}});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
